// File: rtl/sub_serial.sv
// ============================================================================
// Module      : sub_serial
// Description : Bit-serial two's-complement subtractor (diff = a - b), LSB
//               first, one borrow flip-flop. Optional signed-overflow output
//               enabled by defining SUB_SERIAL_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef SUB_SERIAL_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-1:0]   diff_sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_ff_q;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
    logic               zero_q;

    logic               bit_d;
    logic               bout_d;
    logic [WIDTH-1:0]   diff_sr_d;
    logic               last_bit_d;

`ifdef SUB_SERIAL_OVERFLOW_EN
    logic               a_msb_q;
    logic               b_msb_q;
    logic               overflow_q;
    logic               overflow_d;
`endif

    // One full-subtractor cell working on the current LSBs of the operands.
    always_comb begin
        bit_d      = a_sr_q[0] ^ b_sr_q[0] ^ borrow_ff_q;
        bout_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_ff_q);
        diff_sr_d  = {bit_d, diff_sr_q[WIDTH-1:1]};
        last_bit_d = (cnt_q == CNT_W'(WIDTH - 1));
    end

`ifdef SUB_SERIAL_OVERFLOW_EN
    always_comb begin
        overflow_d = (a_msb_q != b_msb_q) && (diff_sr_d[WIDTH-1] != a_msb_q);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_sr_q   <= '0;
            cnt_q       <= '0;
            borrow_ff_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SUB_SERIAL_OVERFLOW_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sr_q      <= a;
                        b_sr_q      <= b;
                        diff_sr_q   <= '0;
                        cnt_q       <= '0;
                        borrow_ff_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
`ifdef SUB_SERIAL_OVERFLOW_EN
                        a_msb_q     <= a[WIDTH-1];
                        b_msb_q     <= b[WIDTH-1];
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sr_q      <= a_sr_q >> 1;
                    b_sr_q      <= b_sr_q >> 1;
                    diff_sr_q   <= diff_sr_d;
                    borrow_ff_q <= bout_d;
                    cnt_q       <= cnt_q + CNT_W'(1);
                    // Result registers move only here, so they hold through RUN.
                    if (last_bit_d) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= diff_sr_d;
                        borrow_q <= bout_d;
                        zero_q   <= (diff_sr_d == '0);
`ifdef SUB_SERIAL_OVERFLOW_EN
                        overflow_q <= overflow_d;
`endif
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
`ifdef SUB_SERIAL_OVERFLOW_EN
    assign overflow = overflow_q;
`endif

endmodule

`default_nettype wire
